// File: rtl/mips32_pkg.sv
// Shared definitions for the pipe_MIPS32 boot loader: state encoding, header
// layout, default memory width and the HLT opcode.
package mips32_pkg;

    localparam int LOADER_ADDR_W = 10;

    // Header word: [31:16] base word address, [15:0] payload length N
    localparam int HDR_BASE_LSB = 16;
    localparam int HDR_BASE_MSB = 31;
    localparam int HDR_LEN_LSB  = 0;
    localparam int HDR_LEN_MSB  = 15;

    localparam logic [5:0] OP_HLT = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_KICK  = 3'd3,
        ST_RUN   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } loader_state_e;

endpackage

// File: rtl/mips32_run_watchdog.sv
// Saturating RUN-cycle counter with a MAX_CYCLES timeout compare.
module mips32_run_watchdog #(
    parameter logic [15:0] MAX_CYCLES = 16'd1000
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] cycle_count,
    output logic        timeout
);

    // Timeout fires on the cycle whose increment makes the count reach the limit
    localparam logic [15:0] LIMIT_M1 = (MAX_CYCLES == 16'd0) ? 16'd0 : MAX_CYCLES - 16'd1;

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 16'd0;
        end else if (en && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_count = cnt_q;
    assign timeout     = en && (cnt_q >= LIMIT_M1);

endmodule

// File: rtl/mips32_prog_loader.sv
// Framed stream -> pipe_MIPS32 memory loader with start strobe and run supervision.
// Optional trailer checksum: define MIPS32_LOADER_CHECKSUM_EN.
module mips32_prog_loader
    import mips32_pkg::*;
#(
    parameter int          ADDR_W     = LOADER_ADDR_W,
    parameter logic [15:0] MAX_CYCLES = 16'd1000
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [31:0]       s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_start,
    input  logic              cpu_halted,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [15:0]       cycle_count
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       n_q, n_d;
    logic [15:0]       idx_q, idx_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              cpu_start_q, cpu_start_d;
    logic              run_first_q, run_first_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
`ifdef MIPS32_LOADER_CHECKSUM_EN
    logic [31:0]       acc_q, acc_d;
`endif

    logic accept_st;
    logic xfer;
    logic wd_timeout;

    assign accept_st = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign s_ready   = accept_st && !rst;
    assign xfer      = s_valid && s_ready;

    mips32_run_watchdog #(.MAX_CYCLES(MAX_CYCLES)) u_watchdog (
        .clk1        (clk1),
        .rst         (rst),
        .clr         (state_q == ST_KICK),
        .en          (state_q == ST_RUN),
        .cycle_count (cycle_count),
        .timeout     (wd_timeout)
    );

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        n_d         = n_q;
        idx_d       = idx_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MIPS32_LOADER_CHECKSUM_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    base_d = s_data[HDR_BASE_LSB +: ADDR_W];
                    n_d    = s_data[HDR_LEN_MSB:HDR_LEN_LSB];
                    idx_d  = 16'd0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    acc_d  = s_data;
                    state_d = (s_data[HDR_LEN_MSB:HDR_LEN_LSB] == 16'd0) ? ST_CHECK : ST_LOAD;
`else
                    if (s_data[HDR_LEN_MSB:HDR_LEN_LSB] == 16'd0) begin
                        state_d = s_last ? ST_KICK : ST_ERR;
                    end else begin
                        state_d = ST_LOAD;
                    end
`endif
                end
            end
            ST_LOAD: begin
                if (xfer) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = base_q + idx_q[ADDR_W-1:0];
                    mem_wdata_d = s_data;
                    idx_d       = idx_q + 16'd1;
`ifdef MIPS32_LOADER_CHECKSUM_EN
                    acc_d       = acc_q ^ s_data;
                    if (idx_q == n_q - 16'd1) begin
                        state_d = s_last ? ST_ERR : ST_CHECK;
                    end else if (s_last) begin
                        state_d = ST_ERR;
                    end
`else
                    if (idx_q == n_q - 16'd1) begin
                        state_d = s_last ? ST_KICK : ST_ERR;
                    end else if (s_last) begin
                        state_d = ST_ERR;
                    end
`endif
                end
            end
`ifdef MIPS32_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) begin
                    state_d = (s_last && (s_data == acc_q)) ? ST_KICK : ST_ERR;
                end
            end
`endif
            ST_KICK: state_d = ST_RUN;
            ST_RUN: begin
                // HALTED is stale in the first RUN cycle; halted outranks timeout
                if (!run_first_q && cpu_halted) begin
                    state_d = ST_DONE;
                end else if (wd_timeout) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase

        // Strobe lands one cycle after KICK so it trails the final memory write
        cpu_start_d = (state_q == ST_KICK);
        run_first_d = (state_q == ST_KICK);
        done_d      = (state_d == ST_DONE);
        error_d     = (state_d == ST_ERR);
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            base_q      <= '0;
            n_q         <= 16'd0;
            idx_q       <= 16'd0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_start_q <= 1'b0;
            run_first_q <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            acc_q       <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            n_q         <= n_d;
            idx_q       <= idx_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_start_q <= cpu_start_d;
            run_first_q <= run_first_d;
            done_q      <= done_d;
            error_q     <= error_d;
`ifdef MIPS32_LOADER_CHECKSUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_start = cpu_start_q;
    assign busy      = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign done      = done_q;
    assign error     = error_q;

endmodule
